strobed_to_axi: RTL

Converts a strobed sample interface into AXI-Stream, the inverse of our AXI-to-strobed converter. Each `in_stb` pulse writes one word and its last flag into an internal circular FIFO, which drains to a standard AXI-Stream master port. An optional programmable packet length forces `o_tlast` independently of `in_last`. Overflow is flagged, never stalls the source, and optionally truncates the damaged packet. The block sits at the boundary between fixed-rate sample sources (radio/DSP) and the AXI-Stream fabric.

---
 rtl/strobed_to_axi.sv | 120 ++++++++++++
 1 files changed

// File: rtl/strobed_to_axi.sv
// rtl/strobed_to_axi.sv - strobed sample source to AXI-Stream master via circular FIFO (optional STROBED_TO_AXI_DROP_PKT_EN)
module strobed_to_axi #(
    parameter int WIDTH     = 32,
    parameter int FIFO_SIZE = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic [15:0]          pkt_len,
    input  logic                 in_stb,
    input  logic                 in_last,
    input  logic [WIDTH-1:0]     in_data,
    output logic [WIDTH-1:0]     o_tdata,
    output logic                 o_tlast,
    output logic                 o_tvalid,
    input  logic                 o_tready,
    output logic                 overflow,
    output logic [FIFO_SIZE:0]   occupied
);

    localparam int DEPTH = 2 ** FIFO_SIZE;

    logic [WIDTH:0]          mem [DEPTH];
    logic [FIFO_SIZE-1:0]    wr_ptr;
    logic [FIFO_SIZE-1:0]    rd_ptr;
    logic [FIFO_SIZE-1:0]    tail_ptr;
    logic [FIFO_SIZE:0]      occ;
    logic [15:0]             cnt;
    logic [16:0]             cnt_plus1;
    logic                    ovf_q;
    logic                    flush;
    logic                    full;
    logic                    last_w;
    logic                    push;
    logic                    pop;
    logic                    drop;
    logic                    in_drop;
    logic                    truncate;

    assign flush     = reset | clear;
    // occ never exceeds DEPTH, so its MSB alone marks a full FIFO
    assign full      = occ[FIFO_SIZE];
    assign cnt_plus1 = {1'b0, cnt} + 17'd1;
    assign last_w    = in_last | ((pkt_len != 16'd0) && (cnt_plus1 >= {1'b0, pkt_len}));
    assign tail_ptr  = wr_ptr - FIFO_SIZE'(1);

`ifdef STROBED_TO_AXI_DROP_PKT_EN
    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] DROP = 1'b1;

    logic [0:0] state;

    assign in_drop  = (state == DROP);
    // Close the damaged packet on the last stored sample unless this strobe ends it anyway
    assign truncate = in_stb & full & ~in_drop & (cnt != 16'd0) & ~last_w;

    // RUN/DROP tracking: discard the remainder of a packet that lost a sample
    always_ff @(posedge clk) begin
        if (flush) begin
            state <= RUN;
        end else if (truncate) begin
            state <= DROP;
        end else if (in_drop && in_stb && last_w) begin
            state <= RUN;
        end
    end
`else
    assign in_drop  = 1'b0;
    assign truncate = 1'b0;
`endif

    assign push = in_stb & ~full & ~in_drop;
    assign drop = in_stb & full & ~in_drop;
    assign pop  = o_tvalid & o_tready;

    // Entry storage; push and truncation are mutually exclusive (truncation only when full)
    always_ff @(posedge clk) begin
        if (!flush) begin
            if (push) begin
                mem[wr_ptr] <= {last_w, in_data};
            end else if (truncate) begin
                mem[tail_ptr][WIDTH] <= 1'b1;
            end
        end
    end

    // Pointers, occupancy, packet sample counter and registered overflow pulse
    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            cnt    <= '0;
            ovf_q  <= 1'b0;
        end else begin
            ovf_q <= drop;
            if (push) begin
                wr_ptr <= wr_ptr + FIFO_SIZE'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_SIZE'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + (FIFO_SIZE + 1)'(1);
                2'b01:   occ <= occ - (FIFO_SIZE + 1)'(1);
                default: occ <= occ;
            endcase
            if (in_stb) begin
                cnt <= last_w ? 16'd0 : cnt + 16'd1;
            end
        end
    end

    assign o_tvalid = (occ != '0);
    assign o_tdata  = mem[rd_ptr][WIDTH-1:0];
    assign o_tlast  = mem[rd_ptr][WIDTH];
    assign overflow = ovf_q;
    assign occupied = occ;

endmodule
